score_display: RTL and testbench

Drives the board's 4-digit, common-anode seven-segment display from the 16-bit game score produced by the pong top level. A sequential double-dabble converter turns the binary score into four BCD digits, clamped to 9999. A scan multiplexer then time-shares the digits on one segment bus. The block sits directly downstream of the score output and needs nothing else from the game.

---
 rtl/score_display_pkg.sv | 48 ++++
 rtl/score_display_bin2bcd_seq.sv | 96 +++++++++
 rtl/score_display.sv | 92 +++++++++
 tb/tb_score_display.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared constants, conversion FSM states and seven-segment codes for score_display.
package score_display_pkg;

    localparam int unsigned CONV_W = 16;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEG_W  = 7;

    localparam logic [CONV_W-1:0] SCORE_MAX = 16'd9999;
    localparam logic [CONV_W-1:0] BCD_MAX   = 16'h9999;
    localparam logic [SEG_W-1:0]  SEG_OFF   = 7'b1111111;

    // Active-low cathodes ordered {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_e;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] digit);
        logic [SEG_W-1:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter: 16 SHIFT cycles then COMMIT, clamping inputs above 9999.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CONV_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [CONV_W-1:0] bcd
);

    localparam int unsigned SR_W = 2 * CONV_W;

    conv_state_e       state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              clamp_q, clamp_d;
    logic [CONV_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [CONV_W-1:0] adj;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            clamp_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            clamp_q  <= clamp_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // sr holds {bcd, bin}; each step corrects nibbles >= 5 before the shift
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        clamp_d  = clamp_q;
        result_d = result_q;
        done_d   = 1'b0;

        adj = sr_q[SR_W-1:CONV_W];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr_q[CONV_W + 4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = sr_q[CONV_W + 4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sr_d    = {{CONV_W{1'b0}}, bin};
                    cnt_d   = '0;
                    clamp_d = (bin > SCORE_MAX);
                end
            end
            SHIFT: begin
                if (!clamp_q) begin
                    sr_d = {adj, sr_q[CONV_W-1:0]} << 1;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d  = COMMIT;
                    done_d   = 1'b1;
                    result_d = clamp_q ? BCD_MAX : sr_d[SR_W-1:CONV_W];
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = result_q;

endmodule

// File: rtl/score_display.sv
// Four-digit seven-segment scan driver for the game score, with on-change BCD conversion.
// Define SCORE_DISPLAY_BLANK_EN to blank leading zero digits (digit 0 always lit).
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned CONV_BITS = CONV_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CONV_BITS-1:0] score,
    output logic [DIGITS-1:0]    an,
    output logic [SEG_W-1:0]     seg,
    output logic                 dp,
    output logic                 busy
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CONV_BITS-1:0] last_score_q, last_score_d;
    logic [CONV_BITS-1:0] cap_q, cap_d;
    logic [CONV_W-1:0]    disp_bcd_q, disp_bcd_d;
    logic [CNT_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [1:0]           digit_idx_q, digit_idx_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 start_c;
    logic                 conv_done;
    logic [CONV_W-1:0]    conv_bcd;
    logic [3:0]           nib;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .bin   (score),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_score_q <= '0;
            cap_q        <= '0;
            disp_bcd_q   <= '0;
            scan_cnt_q   <= '0;
            digit_idx_q  <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
        end else begin
            last_score_q <= last_score_d;
            cap_q        <= cap_d;
            disp_bcd_q   <= disp_bcd_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    // Outputs are built from next-state values so an/seg switch with digit_idx and disp_bcd
    always_comb begin
        start_c      = !busy && (score != last_score_q);
        cap_d        = start_c ? score : cap_q;
        last_score_d = conv_done ? cap_q : last_score_q;
        disp_bcd_d   = conv_done ? conv_bcd : disp_bcd_q;

        scan_cnt_d  = scan_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end

        nib  = disp_bcd_d[{digit_idx_d, 2'b00} +: 4];
        an_d = ~(DIGITS'(1) << digit_idx_d);
        seg_d = seg_decode(nib);
`ifdef SCORE_DISPLAY_BLANK_EN
        if ((digit_idx_d != 2'd0) && ((disp_bcd_d >> {digit_idx_d, 2'b00}) == '0)) begin
            an_d  = '1;
            seg_d = SEG_OFF;
        end
`else
`endif
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: random scores vs. a decimal reference model.
module tb_score_display;

    localparam int unsigned SCAN_DIV = 4;
    localparam time         PERIOD   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [27:0] segs;
        logic [31:0] lit;
        time         fall_t;
        int unsigned val;
    } exp_t;

    exp_t        exp_q[$];
    logic [6:0]  code [10];
    int unsigned p10  [4];
    time         next_free;
    logic [15:0] model_last;

    score_display #(.SCAN_DIV(SCAN_DIV), .CONV_BITS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    initial forever #(PERIOD / 2) clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: clamp to 9999, split decimal digits, blank leading zeros when enabled
    function automatic exp_t model(input logic [15:0] s, input time t);
        exp_t        e;
        int unsigned v;
        int unsigned d;
        logic        blank;
        v = (s > 16'd9999) ? 9999 : int'(s);
        e.val    = v;
        e.fall_t = t + 17 * PERIOD + PERIOD / 2;
        e.segs   = '0;
        e.lit    = '0;
        for (int i = 0; i < 4; i++) begin
            d = (v / p10[i]) % 10;
`ifdef SCORE_DISPLAY_BLANK_EN
            blank = (i > 0) && (v < p10[i]);
`else
            blank = 1'b0;
`endif
            e.segs[i*7 +: 7] = blank ? 7'b1111111 : code[d];
            e.lit[i*8 +: 8]  = blank ? 8'd0 : 8'd4;
        end
        return e;
    endfunction

    // Apply a score for one cycle; the conversion rule is evaluated at the sampling edge
    task automatic tick(input logic [15:0] s);
        score = s;
        @(posedge clk);
        if (reset && ($time >= next_free) && (s != model_last)) begin
            exp_q.push_back(model(s, $time));
            model_last = s;
            next_free  = $time + 18 * PERIOD;
        end
        #1;
    endtask

    // Monitor: on each completed conversion, check timing then one full scan period
    initial begin : monitor
        logic        bp;
        time         rise_t;
        exp_t        e;
        logic [27:0] got;
        int          litc [4];
        int          bad;
        int          idx;
        bp     = 1'b0;
        rise_t = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bp = 1'b0;
            end else begin
                if (busy && !bp) rise_t = $time;
                if (!busy && bp) begin
                    check("pending_expect", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("commit_time", 64'($time), 64'(e.fall_t));
                        check("busy_cycles", 64'(($time - rise_t) / PERIOD), 64'd17);
                        got = {4{7'b1111111}};
                        bad = 0;
                        for (int i = 0; i < 4; i++) litc[i] = 0;
                        for (int k = 0; k < 16; k++) begin
                            if (k > 0) @(negedge clk);
                            if (!reset) break;
                            if (busy && !bp) rise_t = $time;
                            bp = busy;
                            if (dp !== 1'b1) bad++;
                            case (an)
                                4'b1110: idx = 0;
                                4'b1101: idx = 1;
                                4'b1011: idx = 2;
                                4'b0111: idx = 3;
                                4'b1111: idx = -2;
                                default: idx = -1;
                            endcase
                            if (idx >= 0) begin
                                got[idx*7 +: 7] = seg;
                                litc[idx]++;
                            end else if (idx == -2) begin
                                if (seg !== 7'b1111111) bad++;
                            end else begin
                                bad++;
                            end
                        end
                        check("display_segs", 64'(got), 64'(e.segs));
                        check("digit_lit_cycles",
                              64'({8'(litc[3]), 8'(litc[2]), 8'(litc[1]), 8'(litc[0])}), 64'(e.lit));
                        check("scan_bad_samples", 64'(bad), 64'd0);
                    end
                end
                bp = busy;
            end
        end
    end

    initial begin : driver
        logic [15:0] s;
        int          hold;
        code = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        p10        = '{1, 10, 100, 1000};
        model_last = '0;
        next_free  = 0;
        reset      = 1'b0;
        score      = 16'd1234;

        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 64'(an), 64'hF);
        check("rst_seg", 64'(seg), 64'h7F);
        check("rst_dp", 64'(dp), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);

        reset = 1'b1;
        tick(16'd1234);
        check("first_an", 64'(an), 64'hE);
        check("first_seg", 64'(seg), 64'(code[0]));
        check("first_busy", 64'(busy), 64'd1);
        repeat (39) tick(16'd1234);

        repeat (40) tick(16'd12345);
        repeat (40) tick(16'd65535);
        repeat (5)  tick(16'd100);
        repeat (45) tick(16'd200);
        repeat (40) tick(16'd7);
        repeat (40) tick(16'd0);

        // Asynchronous reset in the middle of a conversion
        repeat (6) tick(16'd500);
        reset = 1'b0;
        #1;
        check("midrst_an", 64'(an), 64'hF);
        check("midrst_seg", 64'(seg), 64'h7F);
        check("midrst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        model_last = '0;
        next_free  = 0;
        repeat (3) tick(16'd42);
        reset = 1'b1;
        repeat (40) tick(16'd42);

        repeat (40) begin
            case ($urandom_range(0, 3))
                0:       s = 16'($urandom_range(0, 9));
                1:       s = 16'($urandom_range(0, 9999));
                2:       s = 16'($urandom_range(10000, 65535));
                default: s = 16'($urandom_range(0, 999));
            endcase
            hold = $urandom_range(1, 30);
            repeat (hold) tick(s);
        end
        repeat (60) tick(s);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
